// File: rtl/npu_readback_pkg.sv
// Shared types and constants for the NPU result readback path:
// FSM states, host register map and status word layout.
package npu_readback_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CSUM   = 2'd2;

    localparam int STAT_EMPTY_BIT  = 0;
    localparam int STAT_FULL_BIT   = 1;
    localparam int STAT_OVF_BIT    = 2;
    localparam int STAT_DONE_BIT   = 3;
    localparam int STAT_STATE_LSB  = 4;
    localparam int STAT_BYTES_LSB  = 8;
    localparam int STAT_OCC_LSB    = 16;

    function automatic logic [31:0] pack_status(
        input logic       empty,
        input logic       full,
        input logic       ovf,
        input logic       done,
        input state_e     st,
        input logic [7:0] bytes,
        input logic [7:0] occ
    );
        logic [31:0] w;
        w                        = '0;
        w[STAT_EMPTY_BIT]        = empty;
        w[STAT_FULL_BIT]         = full;
        w[STAT_OVF_BIT]          = ovf;
        w[STAT_DONE_BIT]         = done;
        w[STAT_STATE_LSB +: 2]   = st;
        w[STAT_BYTES_LSB +: 8]   = bytes;
        w[STAT_OCC_LSB +: 8]     = occ;
        return w;
    endfunction

endpackage

// File: rtl/npu_result_readback_if.sv
// Avalon-MM-style host read port of the NPU result readback block.
interface npu_result_readback_if;
    logic        read;
    logic [1:0]  address;
    logic [31:0] readdata;

    modport master (output read, output address, input readdata);
    modport slave  (input read, input address, output readdata);
endinterface

// File: rtl/readback_fifo.sv
// Synchronous word FIFO with flush; a push while full is accepted only
// when a pop frees a slot on the same edge.
module readback_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // NOTE: the storage array carries no reset; empty/count gate every read,
    // so stale contents are never observed and the RAM maps to plain memory.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/npu_result_readback.sv
// NPU result readback: packs D_OUT bytes little-endian into words, buffers
// them and serves data/status/checksum reads. Optional: READBACK_CHECKSUM_EN.
module npu_result_readback
    import npu_readback_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LEN_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         D_OUT,
    input  logic               d_valid,
    input  logic               start,
    input  logic [LEN_W-1:0]   frame_len,
    npu_result_readback_if.slave host,
    output logic               done,
    output logic               overflow
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_e           state;
    state_e           state_next;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] byte_cnt;
    logic [31:0]      pack_q;
    logic [31:0]      word_next;
    logic [1:0]       lane;
    logic             accept;
    logic             last_byte;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [31:0]      fifo_rdata;
    logic [CW-1:0]    fifo_count;
    logic [15:0]      csum_val;
    logic [31:0]      rd_mux;
    logic [31:0]      readdata_q;

    // A start on the same edge wins over any byte or pop in flight.
    assign accept    = (state == ST_COLLECT) && d_valid && !start;
    assign lane      = byte_cnt[1:0];
    assign last_byte = ((byte_cnt + LEN_W'(1)) == len_q);
    assign word_next = pack_q | (32'(D_OUT) << {lane, 3'b000});
    assign push      = accept && ((lane == 2'd3) || last_byte);
    assign pop       = host.read && (host.address == ADDR_DATA) && !fifo_empty && !start;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = (frame_len == '0) ? ST_DONE : ST_COLLECT;
        end else if (accept && last_byte) begin
            state_next = ST_DONE;
        end
    end

    always_comb begin
        done = (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q    <= '0;
            byte_cnt <= '0;
            pack_q   <= '0;
            overflow <= 1'b0;
        end else if (start) begin
            len_q    <= frame_len;
            byte_cnt <= '0;
            pack_q   <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                byte_cnt <= byte_cnt + LEN_W'(1);
                pack_q   <= push ? 32'd0 : word_next;
            end
            if (push && fifo_full && !pop) overflow <= 1'b1;
        end
    end

`ifdef READBACK_CHECKSUM_EN
    logic [15:0] csum_q;
    always_ff @(posedge clk) begin
        if (reset || start) csum_q <= '0;
        else if (accept)    csum_q <= csum_q + 16'(D_OUT);
    end
    assign csum_val = csum_q;
`else
    assign csum_val = '0;
`endif

    readback_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (start),
        .push  (push),
        .pop   (pop),
        .wdata (word_next),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // During a start the status view reflects the freshly cleared frame.
    always_comb begin
        rd_mux = '0;
        case (host.address)
            ADDR_DATA:   rd_mux = pop ? fifo_rdata : 32'd0;
            ADDR_STATUS: rd_mux = start
                ? pack_status(1'b1, 1'b0, 1'b0, state_next == ST_DONE,
                              state_next, 8'd0, 8'd0)
                : pack_status(fifo_empty, fifo_full, overflow, done,
                              state, 8'(byte_cnt), 8'(fifo_count));
            ADDR_CSUM:   rd_mux = start ? 32'd0 : 32'(csum_val);
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)          readdata_q <= '0;
        else if (host.read) readdata_q <= rd_mux;
    end

    assign host.readdata = readdata_q;

endmodule

// File: tb/tb_npu_result_readback.sv
// Directed self-checking bench for npu_result_readback (DEPTH=4).
module tb_npu_result_readback;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       d_valid;
    logic [7:0] D_OUT;
    logic [7:0] frame_len;
    logic       done;
    logic       overflow;
    logic [31:0] rd;
    logic [31:0] exp_csum;
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    npu_result_readback_if bus ();

    npu_result_readback #(.DEPTH(4), .LEN_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .D_OUT     (D_OUT),
        .d_valid   (d_valid),
        .start     (start),
        .frame_len (frame_len),
        .host      (bus),
        .done      (done),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] len);
        start     = 1'b1;
        frame_len = len;
        tick();
        start     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        D_OUT   = b;
        d_valid = 1'b1;
        tick();
        d_valid = 1'b0;
    endtask

    task automatic host_read(input logic [1:0] addr, output logic [31:0] data);
        bus.read    = 1'b1;
        bus.address = addr;
        tick();
        bus.read    = 1'b0;
        data        = bus.readdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
`ifdef READBACK_CHECKSUM_EN
        exp_csum = 32'h0000_02FD;
`else
        exp_csum = 32'h0;
`endif
        reset = 1'b1; start = 1'b0; d_valid = 1'b0; D_OUT = '0; frame_len = '0;
        bus.read = 1'b0; bus.address = 2'd0;
        repeat (2) tick();
        check("rst_readdata", bus.readdata, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_overflow", {31'b0, overflow}, 32'h0);
        reset = 1'b0;
        tick();
        host_read(2'd1, rd);
        check("rst_status", rd, 32'h0000_0001);

        // 8-byte frame, two full words
        do_start(8'd8);
        check("f8_done_low", {31'b0, done}, 32'h0);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        check("f8_done", {31'b0, done}, 32'h1);
        host_read(2'd0, rd); check("f8_w0", rd, 32'h0403_0201);
        host_read(2'd0, rd); check("f8_w1", rd, 32'h0807_0605);
        host_read(2'd1, rd); check("f8_status", rd, 32'h0000_0829);

        // 5-byte frame, partial last word, then empty read
        do_start(8'd5);
        for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i));
        host_read(2'd0, rd); check("f5_w0", rd, 32'hA3A2_A1A0);
        host_read(2'd0, rd); check("f5_w1", rd, 32'h0000_00A4);
        host_read(2'd0, rd); check("f5_empty_read", rd, 32'h0);
        host_read(2'd1, rd); check("f5_status", rd, 32'h0000_0529);
        repeat (3) tick();
        check("f5_hold", bus.readdata, 32'h0000_0529);

        // overflow: 20 bytes into a 4-deep FIFO with no reads
        do_start(8'd20);
        for (int i = 0; i < 20; i++) send_byte(8'h10 + 8'(i));
        check("ovf_flag", {31'b0, overflow}, 32'h1);
        host_read(2'd1, rd); check("ovf_status", rd, 32'h0004_142E);
        host_read(2'd0, rd); check("ovf_head", rd, 32'h1312_1110);
        do_start(8'd8);
        check("ovf_cleared", {31'b0, overflow}, 32'h0);

        // abort after 3 bytes, with a status read in the start cycle
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
        start = 1'b1; frame_len = 8'd5; bus.read = 1'b1; bus.address = 2'd1;
        tick();
        start = 1'b0; bus.read = 1'b0;
        check("abort_status_same_cycle", bus.readdata, 32'h0000_0011);
        host_read(2'd1, rd); check("abort_status", rd, 32'h0000_0011);
        for (int i = 0; i < 5; i++) send_byte(8'hB0 + 8'(i));
        host_read(2'd0, rd); check("abort_lane0", rd, 32'hB3B2_B1B0);
        // start with data read while FIFO still holds a word
        start = 1'b1; frame_len = 8'd0; bus.read = 1'b1; bus.address = 2'd0;
        tick();
        start = 1'b0; bus.read = 1'b0;
        check("start_read_data", bus.readdata, 32'h0);
        check("len0_done", {31'b0, done}, 32'h1);
        host_read(2'd1, rd); check("len0_status", rd, 32'h0000_0029);

        // full FIFO: pop and push of 5th word on the same edge
        do_start(8'd20);
        for (int i = 0; i < 19; i++) send_byte(8'h30 + 8'(i));
        D_OUT = 8'h43; d_valid = 1'b1; bus.read = 1'b1; bus.address = 2'd0;
        tick();
        d_valid = 1'b0; bus.read = 1'b0;
        check("simul_head", bus.readdata, 32'h3332_3130);
        check("simul_no_ovf", {31'b0, overflow}, 32'h0);
        host_read(2'd1, rd); check("simul_status", rd, 32'h0004_142A);
        host_read(2'd0, rd); check("simul_w1", rd, 32'h3736_3534);
        host_read(2'd0, rd); check("simul_w2", rd, 32'h3B3A_3938);
        host_read(2'd0, rd); check("simul_w3", rd, 32'h3F3E_3D3C);
        host_read(2'd0, rd); check("simul_w4", rd, 32'h4342_4140);

        // checksum, reserved address, d_valid ignored in DONE
        do_start(8'd3);
        for (int i = 0; i < 3; i++) send_byte(8'hFF);
        send_byte(8'h99);
        host_read(2'd2, rd); check("csum", rd, exp_csum);
        host_read(2'd3, rd); check("addr3", rd, 32'h0);
        host_read(2'd1, rd); check("done_ignore_status", rd, 32'h0001_0328);
        host_read(2'd0, rd); check("ff_word", rd, 32'h00FF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/npu_result_readback.md
# npu_result_readback

Host-side readback path for NPU results: captures the byte stream the NPU emits on `D_OUT`, packs it little-endian into 32-bit words, buffers the words in a synchronous FIFO, and serves them to the HPS over an Avalon-MM-style read port. It is the read-direction counterpart of the host write path (`writedata`/`control_reg` into the image/conv/dense RAMs). It sits beside `npu_top` inside the memory top level.

## Interface
Parameters:
- `DEPTH`, 16: FIFO depth in 32-bit words; power of two, 2..128.
- `LEN_W`, 8: width of the frame-length and byte counters.

Ports:
- `clk`  in  1  system clock, the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `D_OUT`  in  8  result byte from `npu_top`.
- `d_valid`  in  1  `D_OUT` is valid this cycle (NPU shift-out strobe).
- `start`  in  1  single-cycle pulse: clear the buffer and begin a new frame.
- `frame_len`  in  LEN_W  number of bytes expected in the frame; sampled when `start` is high.
- `read`  in  1  host read strobe.
- `address`  in  2  0 = data, 1 = status, 2 = checksum, 3 = reserved.
- `readdata`  out  32  registered read data.
- `done`  out  1  frame complete: all bytes have been received and pushed.
- `overflow`  out  1  sticky flag: a word was dropped because the FIFO was full.

## Operation
- States: IDLE, COLLECT, DONE.
  - IDLE → COLLECT on `start` with `frame_len` != 0.
  - IDLE → DONE on `start` with `frame_len` == 0.
  - COLLECT → DONE on the edge that accepts the final byte.
  - DONE → COLLECT or DONE on the next `start`.
- `start` in any state:
  - Flushes the FIFO and clears the packer.
  - Clears the byte counter, `overflow`, `done`, and the checksum.
  - Loads `frame_len`.
  - Aborts any frame in progress.
- Byte acceptance: a byte is accepted only in COLLECT when `d_valid` is high; `d_valid` is ignored in IDLE and DONE.
- Packing: byte k of the frame goes to lane k mod 4 (lane 0 = bits [7:0]).
- A word is pushed on the edge that fills lane 3, or on the edge that accepts the last byte of the frame. A partial last word has its unused lanes set to zero.
- FIFO full when a push occurs:
  - If no pop happens in the same cycle, the word is dropped and `overflow` is set (sticky).
  - A push and a pop in the same cycle while full are both performed; nothing is dropped.
- Host reads:
  - `read` with address 0 and FIFO not empty: pop, and `readdata` is the head word.
  - `read` with address 0 and FIFO empty: `readdata` is 0, no pop, no error.
  - Address 1 (status): [0] empty, [1] full, [2] overflow, [3] done, [5:4] state encoding, [15:8] bytes received (low 8 bits), [23:16] FIFO occupancy, [31:24] zero.
  - Address 3 reads 0.
  - Reads at addresses 1, 2 and 3 have no side effects.
- `start` and `read` in the same cycle: the flush takes priority; the read returns 0 for address 0 and the post-clear values for status.

## Timing
- Reset values:
  - `readdata` = 0, `done` = 0, `overflow` = 0.
  - State IDLE, FIFO empty, all counters and the checksum 0.
- Read latency: 1 cycle. `readdata` is valid on the cycle after `read`, and holds until the next `read`.
- A word pushed at edge N is poppable by a `read` sampled at edge N+1.
- `done` rises on the same edge that accepts the final byte.
- Back-to-back `d_valid` at one byte per cycle is sustained with no stalls.

## Configuration
- `READBACK_CHECKSUM_EN` defined:
  - A 16-bit wrapping sum of all accepted bytes is maintained and cleared by `start`.
  - Address 2 returns the sum zero-extended to 32 bits.
- Not defined:
  - No checksum register is built.
  - Address 2 reads 0.

## Structure
- `npu_readback_pkg`:
  - State enum.
  - Address constants `ADDR_DATA`, `ADDR_STATUS`, `ADDR_CSUM`.
  - Status bit-position constants.
- Sub-module `readback_fifo`: synchronous FIFO parameterised by `DEPTH`, with push, pop, flush, full, empty and count. The packer, FSM and read mux live in the top module.

## Test plan
- `start` with `frame_len`=8, bytes 0x01..0x08 on consecutive cycles → two pops return 0x04030201 then 0x08070605; `done`=1.
- `frame_len`=5, bytes 0xA0..0xA4 → pops return 0xA3A2A1A0 then 0x000000A4; a further data read returns 0 and status bit [0] is 1.
- `DEPTH`=4, `frame_len`=20, no reads → the 5th word is dropped, `overflow`=1, occupancy=4; the next `start` clears `overflow`.
- `start` issued after 3 of 8 bytes → FIFO empty, bytes-received=0, state COLLECT; the new frame packs from lane 0.
- Read the full FIFO while pushing the 5th word in the same cycle → no overflow; occupancy stays at 4.
- With `READBACK_CHECKSUM_EN`, bytes 0xFF×3 → address 2 reads 0x000002FD. Without the macro, address 2 reads 0.
